// File: rtl/result_window_accum_pkg.sv
// ---------------------------------------------------------------------------
// result_window_accum_pkg
//   Shared constants and types for the adder-tree result window accumulator.
//   ADDER_* values describe the upstream adder tree. This block and its
//   benches use them so that all of them agree on the result width and on
//   the result latency.
//   No ports (package).
// ---------------------------------------------------------------------------
package result_window_accum_pkg;

  // Upstream adder-tree geometry
  localparam int ADDER_DATA_W   = 8;
  localparam int ADDER_PIPE_LAT = 2;

  // Default window length is 2**RWA_WIN_LOG2 samples
  localparam int RWA_WIN_LOG2   = 2;

  // Single-entry output slot
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/valid_pipe.sv
// ---------------------------------------------------------------------------
// valid_pipe
//   A DEPTH-stage shift register of a valid bit. It realigns an upstream
//   valid with a result that arrives DEPTH cycles later. A synchronous flush
//   zeroes every stage, so valids that are still in flight are dropped.
// Ports
//   clk      in  rising-edge clock
//   clr_n    in  async active-low reset, clears all stages
//   i_flush  in  sync clear of all stages
//   i_d      in  valid entering the line
//   o_q      out valid leaving the line (DEPTH cycles after i_d)
// ---------------------------------------------------------------------------
module valid_pipe
  import result_window_accum_pkg::*;
#(
  parameter int DEPTH = ADDER_PIPE_LAT
) (
  input  logic clk,
  input  logic clr_n,
  input  logic i_flush,
  input  logic i_d,
  output logic o_q
);

  logic [DEPTH-1:0] vld_pipe_d;
  logic [DEPTH-1:0] vld_pipe_q;

  always_comb begin
    vld_pipe_d    = '0;
    vld_pipe_d[0] = i_d;
    for (int i = 1; i < DEPTH; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
    end
    // Flush also kills the valid entering this cycle
    if (i_flush) begin
      vld_pipe_d = '0;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      vld_pipe_q <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
    end
  end

  assign o_q = vld_pipe_q[DEPTH-1];

endmodule

// File: rtl/result_window_accum.sv
// ---------------------------------------------------------------------------
// result_window_accum
//   Consumes the adder-tree result stream. It accumulates fixed windows of
//   2**WIN_LOG2 samples and reports the sum, truncating average, max and min
//   of each window. The results leave over a valid/ready handshake.
//   i_valid is aligned with the adder-tree inputs. The internal delay line
//   realigns it with i_result.
//   Upstream is never stalled. When a window completes while the output slot
//   is still occupied, that window is dropped and a sticky overrun flag is
//   raised.
// Ports
//   clk, clr_n   clock, async active-low reset
//   i_valid      sample valid, aligned with adder-tree inputs
//   i_result     adder-tree result (DATA_W)
//   i_flush      sync abort of the partial window and of in-flight valids
//   i_ready      downstream accepts the window output
//   o_valid      window output valid
//   o_sum        window sum (DATA_W+WIN_LOG2)
//   o_avg        o_sum >> WIN_LOG2
//   o_max/o_min  largest / smallest sample of the window
//   o_overrun    sticky: a completed window was dropped
//   i_ovr_clr    sync clear of o_overrun (a set in the same cycle wins)
// ---------------------------------------------------------------------------
module result_window_accum
  import result_window_accum_pkg::*;
#(
  parameter int DATA_W   = ADDER_DATA_W,
  parameter int WIN_LOG2 = RWA_WIN_LOG2,
  parameter int PIPE_LAT = ADDER_PIPE_LAT
) (
  input  logic                       clk,
  input  logic                       clr_n,
  input  logic                       i_valid,
  input  logic [DATA_W-1:0]          i_result,
  input  logic                       i_flush,
  input  logic                       i_ready,
  output logic                       o_valid,
  output logic [DATA_W+WIN_LOG2-1:0] o_sum,
  output logic [DATA_W-1:0]          o_avg,
  output logic [DATA_W-1:0]          o_max,
  output logic [DATA_W-1:0]          o_min,
  output logic                       o_overrun,
  input  logic                       i_ovr_clr
);

  localparam int SUM_W = DATA_W + WIN_LOG2;
  localparam logic [WIN_LOG2-1:0] CNT_LAST = '1;

  // -------------------------------------------------------------------------
  // Valid realignment
  // -------------------------------------------------------------------------
  logic d_valid;

  valid_pipe #(
    .DEPTH (PIPE_LAT)
  ) u_valid_pipe (
    .clk     (clk),
    .clr_n   (clr_n),
    .i_flush (i_flush),
    .i_d     (i_valid),
    .o_q     (d_valid)
  );

  // -------------------------------------------------------------------------
  // Accumulator
  // -------------------------------------------------------------------------
  logic [WIN_LOG2-1:0] cnt_d,     cnt_q;
  logic [SUM_W-1:0]    acc_sum_d, acc_sum_q;
  logic [DATA_W-1:0]   acc_max_d, acc_max_q;
  logic [DATA_W-1:0]   acc_min_d, acc_min_q;

  // Running totals including the current sample. They feed both the
  // accumulator and the output slot, so a completed window includes its
  // last sample.
  logic [SUM_W-1:0]    fold_sum;
  logic [DATA_W-1:0]   fold_max;
  logic [DATA_W-1:0]   fold_min;
  logic                win_done;

  always_comb begin
    if (cnt_q == '0) begin
      fold_sum = {{WIN_LOG2{1'b0}}, i_result};
      fold_max = i_result;
      fold_min = i_result;
    end else begin
      fold_sum = acc_sum_q + SUM_W'(i_result);
      // Strict compares: on a tie the old value is kept
      fold_max = (i_result > acc_max_q) ? i_result : acc_max_q;
      fold_min = (i_result < acc_min_q) ? i_result : acc_min_q;
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    acc_sum_d = acc_sum_q;
    acc_max_d = acc_max_q;
    acc_min_d = acc_min_q;
    win_done  = 1'b0;
    if (i_flush) begin
      // The partial window is abandoned and a sample on this cycle is
      // discarded. Stale totals are harmless: the next sample loads over them.
      cnt_d = '0;
    end else if (d_valid) begin
      cnt_d     = cnt_q + WIN_LOG2'(1);
      acc_sum_d = fold_sum;
      acc_max_d = fold_max;
      acc_min_d = fold_min;
      win_done  = (cnt_q == CNT_LAST);
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q     <= '0;
      acc_sum_q <= '0;
      acc_max_q <= '0;
      acc_min_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      acc_sum_q <= acc_sum_d;
      acc_max_q <= acc_max_d;
      acc_min_q <= acc_min_d;
    end
  end

  // -------------------------------------------------------------------------
  // Output slot FSM
  // -------------------------------------------------------------------------
  slot_state_e         state_d, state_q;
  logic [SUM_W-1:0]    out_sum_d, out_sum_q;
  logic [DATA_W-1:0]   out_max_d, out_max_q;
  logic [DATA_W-1:0]   out_min_d, out_min_q;
  logic                ovr_d,     ovr_q;
  logic                slot_load;
  logic                ovr_set;

  always_comb begin
    state_d   = state_q;
    slot_load = 1'b0;
    ovr_set   = 1'b0;
    case (state_q)
      SLOT_EMPTY: begin
        if (win_done) begin
          slot_load = 1'b1;
          state_d   = SLOT_FULL;
        end
      end
      SLOT_FULL: begin
        if (i_ready) begin
          // Slot drains this cycle. A window that completes at the same
          // time takes its place without a bubble.
          if (win_done) begin
            slot_load = 1'b1;
          end else begin
            state_d = SLOT_EMPTY;
          end
        end else if (win_done) begin
          // Held data must stay stable, so the new window is lost
          ovr_set = 1'b1;
        end
      end
      default: state_d = SLOT_EMPTY;
    endcase
  end

  always_comb begin
    out_sum_d = out_sum_q;
    out_max_d = out_max_q;
    out_min_d = out_min_q;
    if (slot_load) begin
      out_sum_d = fold_sum;
      out_max_d = fold_max;
      out_min_d = fold_min;
    end
    ovr_d = ovr_q;
    if (ovr_set) begin
      ovr_d = 1'b1;
    end else if (i_ovr_clr) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= SLOT_EMPTY;
      out_sum_q <= '0;
      out_max_q <= '0;
      out_min_q <= '0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_sum_q <= out_sum_d;
      out_max_q <= out_max_d;
      out_min_q <= out_min_d;
      ovr_q     <= ovr_d;
    end
  end

  assign o_valid   = (state_q == SLOT_FULL);
  assign o_sum     = out_sum_q;
  assign o_avg     = out_sum_q[SUM_W-1:WIN_LOG2];
  assign o_max     = out_max_q;
  assign o_min     = out_min_q;
  assign o_overrun = ovr_q;

endmodule

// File: tb/tb_result_window_accum.sv
// ---------------------------------------------------------------------------
// tb_result_window_accum
//   Directed bench for result_window_accum with the default parameters
//   (8-bit results, 4-sample windows, latency 2). A two-register model of
//   the adder tree delays the bench's sample value so that it reaches
//   i_result when the realigned valid does. All expected values are
//   computed by hand.
// ---------------------------------------------------------------------------
module tb_result_window_accum;

  logic        clk;
  logic        clr_n;
  logic        i_valid;
  logic [7:0]  i_result;
  logic        i_flush;
  logic        i_ready;
  logic        o_valid;
  logic [9:0]  o_sum;
  logic [7:0]  o_avg;
  logic [7:0]  o_max;
  logic [7:0]  o_min;
  logic        o_overrun;
  logic        i_ovr_clr;

  int total = 0;
  int bad   = 0;

  // Adder-tree model: sample value driven with i_valid, result 2 cycles later
  logic [7:0] smp, at_r1, at_r2;
  always @(posedge clk) begin
    at_r1 <= smp;
    at_r2 <= at_r1;
  end
  assign i_result = at_r2;

  result_window_accum dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .i_valid   (i_valid),
    .i_result  (i_result),
    .i_flush   (i_flush),
    .i_ready   (i_ready),
    .o_valid   (o_valid),
    .o_sum     (o_sum),
    .o_avg     (o_avg),
    .o_max     (o_max),
    .o_min     (o_min),
    .o_overrun (o_overrun),
    .i_ovr_clr (i_ovr_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Advance one cycle; outputs are then sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] v);
    i_valid = 1'b1;
    smp     = v;
    tick();
    i_valid = 1'b0;
  endtask

  task automatic chk_win(input string tag, input int s, input int a, input int mx, input int mn);
    chk({tag, ".vld"}, o_valid, 1);
    chk({tag, ".sum"}, o_sum, s);
    chk({tag, ".avg"}, o_avg, a);
    chk({tag, ".max"}, o_max, mx);
    chk({tag, ".min"}, o_min, mn);
  endtask

  task automatic accept(input string tag);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    chk({tag, ".drained"}, o_valid, 0);
  endtask

  task automatic wait_ovalid(input string tag, input int lim);
    int n = 0;
    while (!o_valid && n < lim) begin
      tick();
      n++;
    end
    chk({tag, ".arrived"}, o_valid, 1);
  endtask

  initial begin
    clr_n     = 1'b0;
    i_valid   = 1'b0;
    smp       = 8'd0;
    i_flush   = 1'b0;
    i_ready   = 1'b0;
    i_ovr_clr = 1'b0;

    // 1 Reset held with random inputs, then released
    for (int i = 0; i < 6; i++) begin
      i_valid   = 1'($urandom);
      smp       = 8'($urandom);
      i_flush   = 1'($urandom);
      i_ready   = 1'($urandom);
      i_ovr_clr = 1'($urandom);
      tick();
      chk("rst.vld", o_valid, 0);
      chk("rst.sum", o_sum, 0);
    end
    chk("rst.max", o_max, 0);
    chk("rst.min", o_min, 0);
    chk("rst.avg", o_avg, 0);
    chk("rst.ovr", o_overrun, 0);
    i_valid = 1'b0; smp = 8'd0; i_flush = 1'b0; i_ready = 1'b0; i_ovr_clr = 1'b0;
    clr_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst.vld", o_valid, 0);
    end
    chk("post_rst.sum", o_sum, 0);

    // 2 Window of four results of 14, with latency checks
    send(14); send(14); send(14); send(14);
    chk("win.lat+1", o_valid, 0);
    tick();
    chk("win.lat+2", o_valid, 0);
    tick();
    chk_win("win", 56, 14, 14, 14);
    tick();
    chk_win("win.hold", 56, 14, 14, 14);
    accept("win");

    // 3 Extremes
    send(0); send(90); send(45); send(7);
    tick(); tick();
    chk_win("ext", 142, 35, 90, 0);
    accept("ext");

    // 4a Two windows back to back under backpressure: first held, second dropped.
    // The clear is asserted on the drop cycle, and the set wins.
    send(1); send(2); send(3); send(4);
    send(5); send(5); send(5); send(5);
    tick();
    i_ovr_clr = 1'b1;
    tick();
    i_ovr_clr = 1'b0;
    chk_win("bp.held", 10, 2, 4, 1);
    chk("bp.ovr_set", o_overrun, 1);
    i_ovr_clr = 1'b1;
    tick();
    i_ovr_clr = 1'b0;
    chk("bp.ovr_clr", o_overrun, 0);
    chk("bp.still_held", o_sum, 10);
    accept("bp");

    // 4b Same pattern, but ready on the completion cycle: reload, no overrun
    send(1); send(2); send(3); send(4);
    send(5); send(5); send(5); send(5);
    tick();
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    chk_win("bp2", 20, 5, 5, 5);
    chk("bp2.ovr", o_overrun, 0);
    accept("bp2");

    // 5 Flush after 3 of 4 samples; in-flight valids must be discarded
    send(1); send(1); send(1);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    send(14); send(14); send(14); send(14);
    tick(); tick();
    chk_win("flush", 56, 14, 14, 14);
    accept("flush");
    for (int i = 0; i < 4; i++) tick();
    chk("flush.no_extra", o_valid, 0);

    // 6 Gapped partial window killed by async reset, then a fresh window
    send(14); tick(); send(14); tick(); tick();
    #2 clr_n = 1'b0;
    #1;
    chk("arst.vld", o_valid, 0);
    chk("arst.sum", o_sum, 0);
    chk("arst.max", o_max, 0);
    tick();
    clr_n = 1'b1;
    tick();
    chk("arst.idle", o_valid, 0);
    send(3); tick(); send(9); send(1); tick(); tick(); send(6);
    wait_ovalid("gap", 8);
    chk_win("gap", 19, 4, 9, 1);
    chk("gap.ovr", o_overrun, 0);
    accept("gap");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
